// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle between a CPU-side master and a memory responder.
// The request carries a byte strobe; strobe == 0 marks a read.
interface dbus_responder_if;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_responder.sv
// Single-outstanding data-bus memory responder with a fixed response latency.
// Byte-lane writes and full-word reads over DEPTH_WORDS 64-bit words starting at BASE_ADDR.
module dbus_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   dbus_responder_if.slave   bus,
   output logic              busy,
   output logic              err_oob,
   output logic [31:0]       txn_count
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd8;
   localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic [IDX_W-1:0] idx_q;
   logic             in_range_q;
   logic [7:0]       strobe_q;
   logic [63:0]      data_q;
   logic [2:0]       size_q;
   logic             addr_ok_q;
   logic             data_ok_q;
   logic [63:0]      rdata_q;

   logic [63:0]      mem [DEPTH_WORDS];

   logic [63:0]      req_off;
   logic             req_in_range;
   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_in_range;
   logic [63:0]      rd_word;
   logic             unused_size;

   // In IDLE the lookup follows the live request so a zero-latency access
   // can capture its response word on the accept edge itself.
   assign req_off      = bus.dreq.addr - BASE_ADDR;
   assign req_in_range = (bus.dreq.addr >= BASE_ADDR) && (req_off < SPAN);
   assign req_idx      = req_off[IDX_W+2:3];
   assign rd_idx       = (state == IDLE) ? req_idx : idx_q;
   assign rd_in_range  = (state == IDLE) ? req_in_range : in_range_q;
   assign rd_word      = rd_in_range ? mem[rd_idx] : 64'd0;

   assign bus.dresp    = {addr_ok_q, data_ok_q, rdata_q};
   assign unused_size  = ^size_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         strobe_q   <= 8'd0;
         data_q     <= 64'd0;
         size_q     <= 3'd0;
         addr_ok_q  <= 1'b0;
         data_ok_q  <= 1'b0;
         rdata_q    <= 64'd0;
         busy       <= 1'b0;
         err_oob    <= 1'b0;
         txn_count  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.dreq.valid) begin
                  idx_q      <= req_idx;
                  in_range_q <= req_in_range;
                  strobe_q   <= bus.dreq.strobe;
                  data_q     <= bus.dreq.data;
                  size_q     <= bus.dreq.size;
                  busy       <= 1'b1;
                  if (LATENCY == 0) begin
                     state     <= RESP;
                     addr_ok_q <= 1'b1;
                     data_ok_q <= 1'b1;
                     rdata_q   <= rd_word;
                     if (!req_in_range) err_oob <= 1'b1;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= LAT_INIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state     <= RESP;
                  addr_ok_q <= 1'b1;
                  data_ok_q <= 1'b1;
                  rdata_q   <= rd_word;
                  if (!in_range_q) err_oob <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               addr_ok_q <= 1'b0;
               data_ok_q <= 1'b0;
               rdata_q   <= 64'd0;
               busy      <= 1'b0;
               txn_count <= txn_count + 32'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The write lands on the edge closing RESP, after the old word was captured
   // for the response; storage has no reset so contents survive it.
   always_ff @(posedge clk) begin
      if (state == RESP && in_range_q) begin
         for (int i = 0; i < 8; i++) begin
            if (strobe_q[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized self-checking bench for dbus_responder against a word-array reference model.
// A LATENCY=2 instance covers most scenarios; a LATENCY=0 instance covers back-to-back throughput.
module tb_dbus_responder;

   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        busy, err_oob, busy0, err_oob0;
   logic [31:0] txn_count, txn_count0;

   int total = 0;
   int bad   = 0;
   int exp_txn = 0;

   logic [63:0] model [DEPTH];
   bit          known [DEPTH];

   dbus_responder_if bus ();
   dbus_responder_if bus0 ();

   dbus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_oob(err_oob), .txn_count(txn_count));

   dbus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .err_oob(err_oob0), .txn_count(txn_count0));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: expected response word and the resulting memory contents.
   function automatic bit in_range(input logic [63:0] a);
      return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
   endfunction

   function automatic int word_of(input logic [63:0] a);
      return int'((a - BASE) >> 3);
   endfunction

   task automatic model_access(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                               output logic [63:0] exp, output bit exp_known);
      int w;
      exp = 64'd0;
      exp_known = 1'b1;
      if (in_range(a)) begin
         w = word_of(a);
         exp = model[w];
         exp_known = known[w];
         for (int i = 0; i < 8; i++)
            if (s[i]) model[w][8*i +: 8] = d[8*i +: 8];
         if (s == 8'hFF) known[w] = 1'b1;
      end
      exp_txn++;
   endtask

   // Drives one request on the LATENCY=2 instance and measures its response.
   task automatic do_txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                         output bit ok, output int lat, output logic [63:0] rd,
                         output bit busy_seen, output bit single, output bit leak, output bit aok);
      ok = 0; lat = 0; rd = 64'd0; single = 0; leak = 0; aok = 0;
      @(negedge clk);
      bus.dreq.valid = 1'b1; bus.dreq.addr = a; bus.dreq.strobe = s;
      bus.dreq.data = d; bus.dreq.size = 3'd3;
      @(negedge clk);
      busy_seen = busy;
      bus.dreq.valid  = 1'b0;
      bus.dreq.addr   = {$urandom, $urandom};
      bus.dreq.strobe = 8'($urandom);
      bus.dreq.data   = {$urandom, $urandom};
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) @(negedge clk);
         if (bus.dresp.data_ok) begin
            ok = 1; lat = n; rd = bus.dresp.data; aok = bus.dresp.addr_ok;
            break;
         end
         if (bus.dresp.data != 64'd0) leak = 1;
      end
      if (ok) begin
         @(negedge clk);
         single = !bus.dresp.data_ok && (bus.dresp.data == 64'd0);
      end
   endtask

   task automatic test_reset;
      bus.dreq = '0; bus0.dreq = '0;
      rst = 1'b0;
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++; if (err_oob !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", err_oob); end
      total++; if (txn_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_txn: got %h expected 0", txn_count); end
      total++; if (bus.dresp !== '0) begin bad++; $display("[TB] FAIL reset_dresp: got %h expected 0", bus.dresp); end
      total++; if (txn_count0 !== 32'd0) begin bad++; $display("[TB] FAIL reset_txn0: got %h expected 0", txn_count0); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_txn = 0;
   endtask

   task automatic test_basic_rw;
      bit ok, bs, single, leak, aok; int lat; logic [63:0] rd, exp; bit k;
      model_access(BASE + 64'd8, 8'hFF, 64'h1122334455667788, exp, k);
      do_txn(BASE + 64'd8, 8'hFF, 64'h1122334455667788, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || lat != LAT + 1) begin bad++; $display("[TB] FAIL write_latency: got ok=%0b lat=%0d expected lat=%0d", ok, lat, LAT + 1); end
      total++; if (bs !== 1'b1) begin bad++; $display("[TB] FAIL busy_wait: got %b expected 1", bs); end
      total++; if (!single) begin bad++; $display("[TB] FAIL write_pulse: got multi-cycle or stale data expected single pulse"); end
      model_access(BASE + 64'd8, 8'h00, 64'd0, exp, k);
      do_txn(BASE + 64'd8, 8'h00, 64'hDEAD_BEEF_0000_0000, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || rd !== exp) begin bad++; $display("[TB] FAIL read_back: got %h expected %h", rd, exp); end
      total++; if (leak) begin bad++; $display("[TB] FAIL data_idle_zero: got nonzero data expected 0 outside data_ok"); end
      total++; if (txn_count !== 32'd2) begin bad++; $display("[TB] FAIL txn_after_two: got %0d expected 2", txn_count); end
   endtask

   task automatic test_partial_write;
      bit ok, bs, single, leak, aok; int lat; logic [63:0] rd, exp; bit k;
      model_access(BASE + 64'd8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, exp, k);
      do_txn(BASE + 64'd8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || rd !== 64'h1122334455667788) begin bad++; $display("[TB] FAIL prewrite_data: got %h expected 1122334455667788", rd); end
      model_access(BASE + 64'd13, 8'h00, 64'd0, exp, k);
      do_txn(BASE + 64'd13, 8'h00, 64'd0, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || rd !== 64'h11223344BBBBBBBB) begin bad++; $display("[TB] FAIL partial_merge: got %h expected 11223344bbbbbbbb", rd); end
   endtask

   task automatic test_random;
      bit ok, bs, single, leak, aok; int lat; logic [63:0] rd, exp, a, d; logic [7:0] s; bit k;
      int errs, w;
      errs = 0;
      // Words 0..7 and the top 8 words, so the last legal word is exercised.
      for (int i = 0; i < 16; i++) begin
         w = (i < 8) ? i : DEPTH - 16 + i;
         a = BASE + 64'(w) * 64'd8;
         d = {$urandom, $urandom};
         model_access(a, 8'hFF, d, exp, k);
         do_txn(a, 8'hFF, d, ok, lat, rd, bs, single, leak, aok);
         if (!ok || lat != LAT + 1) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("[TB] FAIL init_writes: got %0d bad responses expected 0", errs); end
      for (int i = 0; i < 40; i++) begin
         w = $urandom_range(0, 15);
         w = (w < 8) ? w : DEPTH - 16 + w;
         a = BASE + 64'(w) * 64'd8 + 64'($urandom_range(0, 7));
         s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         d = {$urandom, $urandom};
         model_access(a, s, d, exp, k);
         do_txn(a, s, d, ok, lat, rd, bs, single, leak, aok);
         total++;
         if (!ok || lat != LAT + 1 || !aok || !single || leak || (k && rd !== exp)) begin
            bad++;
            $display("[TB] FAIL random_txn%0d: got ok=%0b lat=%0d data=%h expected lat=%0d data=%h", i, ok, lat, rd, LAT + 1, exp);
         end
      end
      total++; if (txn_count !== 32'(exp_txn)) begin bad++; $display("[TB] FAIL random_txn_count: got %0d expected %0d", txn_count, exp_txn); end
   endtask

   task automatic test_oob;
      bit ok, bs, single, leak, aok; int lat; logic [63:0] rd, exp; bit k;
      total++; if (err_oob !== 1'b0) begin bad++; $display("[TB] FAIL oob_pre: got %b expected 0", err_oob); end
      model_access(BASE - 64'd8, 8'h00, 64'd0, exp, k);
      do_txn(BASE - 64'd8, 8'h00, 64'd0, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || lat != LAT + 1 || rd !== 64'd0) begin bad++; $display("[TB] FAIL oob_low: got ok=%0b lat=%0d data=%h expected lat=%0d data=0", ok, lat, rd, LAT + 1); end
      total++; if (err_oob !== 1'b1) begin bad++; $display("[TB] FAIL oob_flag: got %b expected 1", err_oob); end
      model_access(BASE + 64'(DEPTH) * 64'd8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, exp, k);
      do_txn(BASE + 64'(DEPTH) * 64'd8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || rd !== 64'd0) begin bad++; $display("[TB] FAIL oob_high: got %h expected 0", rd); end
      model_access(BASE, 8'h00, 64'd0, exp, k);
      do_txn(BASE, 8'h00, 64'd0, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || rd !== exp) begin bad++; $display("[TB] FAIL oob_no_write: got %h expected %h", rd, exp); end
      total++; if (err_oob !== 1'b1) begin bad++; $display("[TB] FAIL oob_sticky: got %b expected 1", err_oob); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] dv [3];
      logic [63:0] rd [3];
      bit okv [6];
      int pat_err;
      for (int i = 0; i < 3; i++) dv[i] = {$urandom, $urandom};
      for (int pass = 0; pass < 2; pass++) begin
         pat_err = 0;
         @(negedge clk);
         bus0.dreq.valid = 1'b1; bus0.dreq.addr = BASE; bus0.dreq.size = 3'd3;
         bus0.dreq.strobe = (pass == 0) ? 8'hFF : 8'h00; bus0.dreq.data = dv[0];
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            okv[k-1] = bus0.dresp.data_ok;
            if (bus0.dresp.data_ok) rd[(k-1)/2] = bus0.dresp.data;
            if (k == 1 || k == 3) begin
               bus0.dreq.addr = BASE + 64'd8 * 64'((k + 1) / 2);
               bus0.dreq.data = dv[(k + 1) / 2];
            end
            if (k == 5) bus0.dreq.valid = 1'b0;
         end
         for (int k = 0; k < 6; k++) if (okv[k] != ((k % 2) == 0)) pat_err++;
         total++; if (pat_err != 0) begin bad++; $display("[TB] FAIL b2b_pattern%0d: got %0b%0b%0b%0b%0b%0b expected 101010", pass, okv[0], okv[1], okv[2], okv[3], okv[4], okv[5]); end
      end
      for (int i = 0; i < 3; i++) begin
         total++; if (rd[i] !== dv[i]) begin bad++; $display("[TB] FAIL b2b_read%0d: got %h expected %h", i, rd[i], dv[i]); end
      end
      total++; if (txn_count0 !== 32'd6) begin bad++; $display("[TB] FAIL b2b_txn_count: got %0d expected 6", txn_count0); end
   endtask

   task automatic test_reset_abort;
      logic [63:0] old;
      bit seen; bit ok; int lat; logic [63:0] rd;
      old = model[5];
      @(negedge clk);
      bus.dreq.valid = 1'b1; bus.dreq.addr = BASE + 64'd40; bus.dreq.strobe = 8'hFF;
      bus.dreq.data = ~old;
      @(negedge clk);
      bus.dreq.valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
      total++; if (txn_count !== 32'd0) begin bad++; $display("[TB] FAIL abort_txn: got %0d expected 0", txn_count); end
      total++; if (err_oob !== 1'b0) begin bad++; $display("[TB] FAIL abort_err: got %b expected 0", err_oob); end
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.dresp.data_ok) seen = 1;
      end
      total++; if (seen) begin bad++; $display("[TB] FAIL abort_no_resp: got data_ok expected none"); end
      // Release reset with a read already pending so the very first edge accepts it.
      rst = 1'b1;
      bus.dreq.valid = 1'b1; bus.dreq.addr = BASE + 64'd40; bus.dreq.strobe = 8'h00;
      exp_txn = 1;
      ok = 0; lat = 0; rd = 64'd0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) bus.dreq.valid = 1'b0;
         if (bus.dresp.data_ok) begin ok = 1; lat = n; rd = bus.dresp.data; break; end
      end
      total++; if (!ok || lat != LAT + 1) begin bad++; $display("[TB] FAIL first_after_reset: got ok=%0b lat=%0d expected lat=%0d", ok, lat, LAT + 1); end
      total++; if (rd !== old) begin bad++; $display("[TB] FAIL abort_no_write: got %h expected %h", rd, old); end
   endtask

   task automatic test_txn_wrap;
      bit ok, bs, single, leak, aok; int lat; logic [63:0] rd;
      @(negedge clk);
      force dut.txn_count = 32'hFFFF_FFFF;
      #1 release dut.txn_count;
      #1;
      total++; if (txn_count !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL wrap_preset: got %h expected ffffffff", txn_count); end
      do_txn(BASE, 8'h00, 64'd0, ok, lat, rd, bs, single, leak, aok);
      total++; if (!ok || txn_count !== 32'd0) begin bad++; $display("[TB] FAIL txn_wrap: got %h expected 0", txn_count); end
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_partial_write();
      test_random();
      test_oob();
      test_back_to_back();
      test_reset_abort();
      test_txn_wrap();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
